wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
- Parametrised successor to the 2:1 writeback mux (data memory vs ALU).
- Selects one of NUM_SRC writeback sources (ALU, data memory, PC+4, immediate, ...) per beat and registers the result with destination-register metadata.
- Has a valid/ready handshake with a 2-entry skid buffer, so the writeback stage can stall the pipeline without losing beats.
- Sits between the MEM/WB pipeline boundary and the register file write port.

Parameters:
- DATA_W, 64, width of each source and of the output data.
- NUM_SRC, 4, number of selectable sources (legal range 2..16).
- SEL_W, $clog2(NUM_SRC), width of the binary select.
- RD_W, 5, destination register address width.
- ZERO_REG, 31, register index hardwired to zero (XZR); writes to it are suppressed.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- src_data  in  NUM_SRC*DATA_W  packed sources; source k is at bits [k*DATA_W +: DATA_W].
- src_sel  in  SEL_W  binary source select.
- in_rd  in  RD_W  destination register.
- in_reg_write  in  1  register-file write enable for the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  register file / downstream accepts the beat.
- out_data  out  DATA_W  selected data.
- out_rd  out  RD_W  destination register.
- out_reg_write  out  1  effective write enable.
- sel_error  out  1  one-cycle pulse when an accepted beat had src_sel >= NUM_SRC.

Behaviour:
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A beat is consumed when out_valid && out_ready.
  - Once out_valid is asserted, out_data, out_rd and out_reg_write stay stable until the beat is consumed.
- Storage: main register drives the outputs; a skid register holds one overflow beat.
- State machine, encoded in main_v/skid_v:
  - EMPTY: on accept -> ONE (beat into main).
  - ONE: accept without consume -> FULL (beat into skid); consume without accept -> EMPTY; accept with consume -> ONE (new beat into main).
  - FULL: consume -> ONE (skid moves to main; no accept is possible because in_ready=0).
- in_ready = !skid_v, registered; it depends on no combinational path from out_ready.
- Latency: an accepted beat appears on out_* on the next rising edge. Sustained throughput is 1 beat/cycle while out_ready=1.
- Mux arithmetic:
  - Selection is performed at accept time and the stored value is the selected DATA_W word.
  - If src_sel >= NUM_SRC: stored data = 0, stored write enable = 0, and sel_error is asserted for exactly the cycle after accept.
- Zero register: out_reg_write = stored in_reg_write && (stored rd != ZERO_REG). out_data is still presented unmodified.
- Reset:
  - Outputs: out_valid=0, out_data=0, out_rd=0, out_reg_write=0, sel_error=0, in_ready=1 (in the cycle after reset).
  - Both skid registers clear. Reset mid-stream drops every held beat, with no partial output.
- Boundaries:
  - An out_ready toggle while in FULL never duplicates or drops a beat.
  - An in_valid beat while in_ready=0 is ignored; upstream must hold it.

Optional Feature:
- WB_SELECT_BYPASS_EN.
- Defined:
  - In EMPTY with out_ready=1, an accepted beat is driven combinationally to out_* in the same cycle (0 latency) and is not stored.
  - All other states behave as above.
  - sel_error for a bypassed beat pulses in the accept cycle.
- Undefined: fixed 1-cycle latency as specified.

Decomposition:
- Shared package (wb_pkg):
  - ZERO_REG default 31.
  - Source index constants: SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_IMM=3.
  - Beat struct: data, rd, reg_write, sel_err.
- Sub-module wb_skid_buffer: generic 2-entry valid/ready skid buffer over the beat struct width. The top module performs select/zero-register logic and instantiates it.

Test Plan:
- Reset, then accept beat sel=1 (MEM=42), rd=3, write=1, out_ready=1 -> next cycle out_valid=1, out_data=42, out_rd=3, out_reg_write=1.
- sel=0 (ALU=23), sel=2 (PC4=0x1004), sel=3 (IMM=7) back to back with out_ready=1 -> outputs 23, 0x1004, 7 on consecutive cycles; in_ready never drops.
- out_ready=0 and send 3 beats (10, 11, 12) -> beats 10 and 11 held, in_ready=0 after the 2nd accept; raise out_ready -> 10, 11, 12 delivered in order with no loss or duplication.
- NUM_SRC=3, send sel=3 -> out_data=0, out_reg_write=0, sel_error high for exactly 1 cycle.
- rd=31, write=1, data=99 -> out_data=99, out_reg_write=0.
- Reset asserted while FULL -> the following cycle out_valid=0, in_ready=1; no stale beats appear afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback-select definitions: default widths, source indices, beat layout.
package wb_pkg;

    localparam int unsigned WB_DATA_W   = 64;
    localparam int unsigned WB_RD_W     = 5;
    localparam int unsigned WB_ZERO_REG = 31;

    // Conventional writeback source slots
    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MEM = 1;
    localparam int unsigned SRC_PC4 = 2;
    localparam int unsigned SRC_IMM = 3;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_RD_W-1:0]   rd;
        logic                 reg_write;
        logic                 sel_err;
    } wb_beat_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer. The main register drives the output;
// the skid register catches one overflow beat so in_ready can stay registered.
module wb_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Encoding is {skid_v, main_v}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             push, pop;
    logic             load_main, load_skid, main_from_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state and register-load decisions
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (!push && pop) begin
                    state_nxt = EMPTY;
                end else if (push && pop) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State and storage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback source select stage: picks one of NUM_SRC sources at accept time,
// buffers the beat through a 2-entry skid buffer and suppresses writes to the
// zero register. Optional macro WB_SELECT_BYPASS_EN adds a 0-latency path
// when the buffer is empty and downstream is ready.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W   = WB_DATA_W,
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned SEL_W    = $clog2(NUM_SRC),
    parameter int unsigned RD_W     = WB_RD_W,
    parameter int unsigned ZERO_REG = WB_ZERO_REG
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [RD_W-1:0]           in_rd,
    input  logic                      in_reg_write,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [RD_W-1:0]           out_rd,
    output logic                      out_reg_write,
    output logic                      sel_error
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
    } stage_beat_t;

    localparam int unsigned BEAT_W = $bits(stage_beat_t);

    stage_beat_t       in_beat, out_beat, shown;
    logic [BEAT_W-1:0] buf_out;
    logic [DATA_W-1:0] sel_data;
    logic              bad_sel;
    logic              buf_in_valid, buf_out_valid, buf_accept;
    logic              sel_err_q;

    assign bad_sel = (32'(src_sel) >= NUM_SRC);

    // Source mux; out-of-range selects fall through to zero
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(src_sel) == k) begin
                sel_data = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Beat as it will be stored
    always_comb begin
        in_beat.data      = bad_sel ? '0 : sel_data;
        in_beat.rd        = in_rd;
        in_beat.reg_write = in_reg_write && !bad_sel;
    end

    wb_skid_buffer #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (buf_in_valid),
        .in_ready (in_ready),
        .in_data  (in_beat),
        .out_valid(buf_out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign out_beat   = buf_out;
    assign buf_accept = buf_in_valid && in_ready;

`ifdef WB_SELECT_BYPASS_EN
    // Buffer empty implies in_ready, so a bypassed beat is always an accepted one
    logic bypass;
    assign bypass        = in_valid && !buf_out_valid && out_ready;
    assign buf_in_valid  = in_valid && !bypass;
    assign out_valid     = buf_out_valid || bypass;
    assign shown         = bypass ? in_beat : out_beat;
    assign sel_error     = sel_err_q || (bypass && bad_sel);
`else
    assign buf_in_valid  = in_valid;
    assign out_valid     = buf_out_valid;
    assign shown         = out_beat;
    assign sel_error     = sel_err_q;
`endif

    assign out_data      = shown.data;
    assign out_rd        = shown.rd;
    assign out_reg_write = shown.reg_write && (shown.rd != RD_W'(ZERO_REG));

    // One-cycle error pulse following a stored beat with an illegal select
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= buf_accept && bad_sel;
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: a 4-source and a 3-source instance share
// one stimulus stream; expected beats are queued on accept and popped by monitors.
module tb_wb_select_stage;

    import wb_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [255:0] src_data;
    logic [1:0]   src_sel;
    logic [4:0]   in_rd;
    logic         in_reg_write;

    logic         in_ready4, out_valid4, out_reg_write4, sel_error4;
    logic [63:0]  out_data4;
    logic [4:0]   out_rd4;
    logic         in_ready3, out_valid3, out_reg_write3, sel_error3;
    logic [63:0]  out_data3;
    logic [4:0]   out_rd3;

    exp_t q4[$];
    exp_t q3[$];
    int   checks;
    int   failures;

    wb_select_stage #(
        .DATA_W(64), .NUM_SRC(4), .RD_W(5), .ZERO_REG(31)
    ) dut4 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready4),
        .src_data     (src_data),
        .src_sel      (src_sel),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .out_valid    (out_valid4),
        .out_ready    (out_ready),
        .out_data     (out_data4),
        .out_rd       (out_rd4),
        .out_reg_write(out_reg_write4),
        .sel_error    (sel_error4)
    );

    wb_select_stage #(
        .DATA_W(64), .NUM_SRC(3), .RD_W(5), .ZERO_REG(31)
    ) dut3 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready3),
        .src_data     (src_data[191:0]),
        .src_sel      (src_sel),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .out_valid    (out_valid3),
        .out_ready    (out_ready),
        .out_data     (out_data3),
        .out_rd       (out_rd3),
        .out_reg_write(out_reg_write3),
        .sel_error    (sel_error3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Monitors: compare every consumed beat against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid4 && out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_beat4: got unexpected data=%h rd=%0d wr=%b, required no beat",
                         out_data4, out_rd4, out_reg_write4);
            end else begin
                e = q4.pop_front();
                chk("out_beat4", 128'({out_data4, out_rd4, out_reg_write4}), 128'({e.d, e.rd, e.wr}));
            end
        end
        if (!reset && out_valid3 && out_ready) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_beat3: got unexpected data=%h rd=%0d wr=%b, required no beat",
                         out_data3, out_rd3, out_reg_write3);
            end else begin
                e = q3.pop_front();
                chk("out_beat3", 128'({out_data3, out_rd3, out_reg_write3}), 128'({e.d, e.rd, e.wr}));
            end
        end
    end

    // Present one beat and hold it until accepted; returns #1 after the accept edge
    task automatic send(input logic [1:0] sel, input logic [63:0] val, input logic [4:0] rd,
                        input logic wr, input logic [63:0] e4_d, input logic e4_wr,
                        input logic [63:0] e3_d, input logic e3_wr, input logic e3_err);
        logic [255:0] s;
        int unsigned  n;
        s = {64'd7, 64'h1004, 64'd42, 64'd23};
        s[sel*64 +: 64] = val;
        src_data     = s;
        src_sel      = sel;
        in_rd        = rd;
        in_reg_write = wr;
        in_valid     = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready4) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck at 0 for beat val=%h, required 1", val);
            in_valid = 1'b0;
            return;
        end
        q4.push_back('{d: e4_d, rd: rd, wr: e4_wr});
        q3.push_back('{d: e3_d, rd: rd, wr: e3_wr});
        @(posedge clk);
        #1;
        chk("sel_error4", 128'(sel_error4), 128'(1'b0));
        chk("sel_error3", 128'(sel_error3), 128'(e3_err));
    endtask

    task automatic idle(input int unsigned cycles);
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        src_data     = '0;
        src_sel      = '0;
        in_rd        = '0;
        in_reg_write = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid4), 128'(1'b0));
        chk("rst_out_data", 128'(out_data4), 128'(64'd0));
        chk("rst_out_rd", 128'(out_rd4), 128'(5'd0));
        chk("rst_out_reg_write", 128'(out_reg_write4), 128'(1'b0));
        chk("rst_sel_error", 128'(sel_error4), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready4), 128'(1'b1));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(in_ready4), 128'(1'b1));

        // Single MEM beat, one-cycle latency
        out_ready = 1'b1;
        send(2'(SRC_MEM), 64'd42, 5'd3, 1'b1, 64'd42, 1'b1, 64'd42, 1'b1, 1'b0);
        chk("latency_valid", 128'(out_valid4), 128'(1'b1));
        chk("latency_data", 128'(out_data4), 128'(64'd42));
        idle(1);

        // Back-to-back ALU, PC4, IMM; IMM is out of range for the 3-source instance
        send(2'(SRC_ALU), 64'd23, 5'd4, 1'b1, 64'd23, 1'b1, 64'd23, 1'b1, 1'b0);
        chk("b2b_in_ready0", 128'(in_ready4), 128'(1'b1));
        send(2'(SRC_PC4), 64'h1004, 5'd5, 1'b1, 64'h1004, 1'b1, 64'h1004, 1'b1, 1'b0);
        chk("b2b_in_ready1", 128'(in_ready4), 128'(1'b1));
        send(2'(SRC_IMM), 64'd7, 5'd6, 1'b1, 64'd7, 1'b1, 64'd0, 1'b0, 1'b1);
        chk("b2b_in_ready2", 128'(in_ready4), 128'(1'b1));
        idle(1);
        chk("sel_error_one_cycle", 128'(sel_error3), 128'(1'b0));

        // Zero register: data passes, write suppressed
        send(2'(SRC_ALU), 64'd99, 5'd31, 1'b1, 64'd99, 1'b0, 64'd99, 1'b0, 1'b0);
        idle(2);

        // Stall: two beats fill the buffer, third waits until out_ready rises
        out_ready = 1'b0;
        send(2'(SRC_MEM), 64'd10, 5'd7, 1'b1, 64'd10, 1'b1, 64'd10, 1'b1, 1'b0);
        send(2'(SRC_MEM), 64'd11, 5'd8, 1'b1, 64'd11, 1'b1, 64'd11, 1'b1, 1'b0);
        chk("full_in_ready", 128'(in_ready4), 128'(1'b0));
        chk("full_hold_data", 128'(out_data4), 128'(64'd10));
        fork
            send(2'(SRC_MEM), 64'd12, 5'd9, 1'b0, 64'd12, 1'b0, 64'd12, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_hold_data", 128'(out_data4), 128'(64'd10));
                chk("stall_hold_rd", 128'(out_rd4), 128'(5'd7));
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("stall_drained4", 128'(q4.size()), 128'(0));
        chk("stall_drained3", 128'(q3.size()), 128'(0));

        // out_ready toggling while FULL
        out_ready = 1'b0;
        send(2'(SRC_MEM), 64'h1111, 5'd10, 1'b1, 64'h1111, 1'b1, 64'h1111, 1'b1, 1'b0);
        send(2'(SRC_ALU), 64'h2222, 5'd11, 1'b1, 64'h2222, 1'b1, 64'h2222, 1'b1, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            out_ready = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(3);
        chk("toggle_drained4", 128'(q4.size()), 128'(0));
        chk("toggle_drained3", 128'(q3.size()), 128'(0));

        // Reset while FULL drops both held beats
        out_ready = 1'b0;
        send(2'(SRC_MEM), 64'h3333, 5'd12, 1'b1, 64'h3333, 1'b1, 64'h3333, 1'b1, 1'b0);
        send(2'(SRC_MEM), 64'h4444, 5'd13, 1'b1, 64'h4444, 1'b1, 64'h4444, 1'b1, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        q4.delete();
        q3.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 128'(out_valid4), 128'(1'b0));
        chk("midrst_in_ready", 128'(in_ready4), 128'(1'b1));
        chk("midrst_out_data", 128'(out_data4), 128'(64'd0));
        reset     = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("midrst_no_stale", 128'(out_valid4), 128'(1'b0));
        send(2'(SRC_PC4), 64'h1004, 5'd1, 1'b1, 64'h1004, 1'b1, 64'h1004, 1'b1, 1'b0);
        idle(3);
        chk("final_drained4", 128'(q4.size()), 128'(0));
        chk("final_drained3", 128'(q3.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
